// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - iterative radix-2 restoring DIV/DIVU unit for the EX stage
// Optional: define DIV_ZERO_FAST_EN to finish divide-by-zero in one stall cycle.
module div_iter_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             startE,
   input  logic             signedE,
   input  logic [WIDTH-1:0] aE,
   input  logic [WIDTH-1:0] bE,
   input  logic             pipe_stallE,
   input  logic             cancel,
   output logic             div_stallE,
   output logic             div_doneE,
   output logic [WIDTH-1:0] quotE,
   output logic [WIDTH-1:0] remE
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] partRem;
   logic [WIDTH-1:0] partQuot;
   logic             quotNeg;
   logic             remNeg;

   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] nextRem;
   logic [WIDTH-1:0] nextQuot;

   assign absA = (signedE && aE[WIDTH-1]) ? -aE : aE;
   assign absB = (signedE && bE[WIDTH-1]) ? -bE : bE;

   // Shifted remainder can need WIDTH+1 bits; bit WIDTH of the trial is the borrow.
   assign shifted  = {partRem, partQuot[WIDTH-1]};
   assign trial    = shifted - {1'b0, divisor};
   assign nextRem  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign nextQuot = {partQuot[WIDTH-2:0], ~trial[WIDTH]};

   always_comb begin
      div_stallE = 1'b0;
      case (state)
         IDLE:    div_stallE = startE & ~cancel;
         BUSY:    div_stallE = ~cancel;
         default: div_stallE = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         divisor   <= '0;
         partRem   <= '0;
         partQuot  <= '0;
         quotNeg   <= 1'b0;
         remNeg    <= 1'b0;
         quotE     <= '0;
         remE      <= '0;
         div_doneE <= 1'b0;
      end else if (cancel) begin
         state     <= IDLE;
         div_doneE <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (startE) begin
`ifdef DIV_ZERO_FAST_EN
                  if (bE == '0) begin
                     state     <= DONE;
                     div_doneE <= 1'b1;
                     quotE     <= (signedE && aE[WIDTH-1]) ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
                     remE      <= aE;
                  end else begin
`else
                  begin
`endif
                     divisor  <= absB;
                     partQuot <= absA;
                     partRem  <= '0;
                     count    <= '0;
                     quotNeg  <= signedE & (aE[WIDTH-1] ^ bE[WIDTH-1]);
                     remNeg   <= signedE & aE[WIDTH-1];
                     state    <= BUSY;
                  end
               end
            end
            BUSY: begin
               partRem  <= nextRem;
               partQuot <= nextQuot;
               count    <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  state     <= DONE;
                  div_doneE <= 1'b1;
                  quotE     <= quotNeg ? -nextQuot : nextQuot;
                  remE      <= remNeg ? -nextRem : nextRem;
               end
            end
            DONE: begin
               // Result is held while EX is frozen so the same instruction is not redone.
               if (!pipe_stallE) begin
                  state     <= IDLE;
                  div_doneE <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
